vga_rect_fill: RTL and testbench



---
 rtl/vga_rect_fill_pkg.sv | 29 ++
 rtl/vga_rect_fill_if.sv | 34 +++
 rtl/vga_rect_fill_address_translator.sv | 22 ++
 rtl/vga_rect_fill.sv | 140 ++++++++++++++
 tb/tb_vga_rect_fill.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/vga_rect_fill_pkg.sv
// Shared definitions for the rectangle fill engine.
//   - Resolution constants for the two supported modes (320x240 and 160x120).
//   - Colour width helper (1 bit in monochrome, else three channels).
//   - FSM state encoding used by vga_rect_fill.
package vga_rect_fill_pkg;

   localparam int XRES_HI = 320;
   localparam int YRES_HI = 240;
   localparam int XW_HI   = 9;
   localparam int YW_HI   = 8;
   localparam int AW_HI   = 17;

   localparam int XRES_LO = 160;
   localparam int YRES_LO = 120;
   localparam int XW_LO   = 8;
   localparam int YW_LO   = 7;
   localparam int AW_LO   = 15;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int colour_width(input bit mono, input int bits_per_channel);
      return mono ? 1 : 3 * bits_per_channel;
   endfunction

endpackage

// File: rtl/vga_rect_fill_if.sv
// Command and video-memory write bundle of the rectangle fill engine.
//   master : issues commands, observes writes/status (command source side)
//   slave  : the fill engine (accepts commands, drives writes/status)
// Signals: cmd_valid/cmd_ready handshake, cmd_x/cmd_y/cmd_w/cmd_h/cmd_colour
// command fields, wr_en/wr_address/wr_colour write port, busy, done.
interface vga_rect_fill_if #(
   parameter int XW = 9,
   parameter int YW = 8,
   parameter int AW = 17,
   parameter int CW = 12
);
   logic          cmd_valid;
   logic          cmd_ready;
   logic [XW-1:0] cmd_x;
   logic [YW-1:0] cmd_y;
   logic [XW-1:0] cmd_w;
   logic [YW-1:0] cmd_h;
   logic [CW-1:0] cmd_colour;
   logic          wr_en;
   logic [AW-1:0] wr_address;
   logic [CW-1:0] wr_colour;
   logic          busy;
   logic          done;

   modport master (
      output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour,
      input  cmd_ready, wr_en, wr_address, wr_colour, busy, done
   );

   modport slave (
      input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour,
      output cmd_ready, wr_en, wr_address, wr_colour, busy, done
   );
endinterface

// File: rtl/vga_rect_fill_address_translator.sv
// vga_address_translator: combinational (x, y) -> linear video-memory
// address, address = y*XRES + x, built from shifts so it matches the
// scan-out side exactly.
//   x           in  XW  column
//   y           in  YW  row
//   mem_address out AW  linear address
module vga_address_translator #(
   parameter string RESOLUTION = "320x240",
   parameter int    XW         = 9,
   parameter int    YW         = 8,
   parameter int    AW         = 17
) (
   input  logic [XW-1:0] x,
   input  logic [YW-1:0] y,
   output logic [AW-1:0] mem_address
);
   // 320 = 256 + 64, 160 = 128 + 32
   localparam int SH_A = (RESOLUTION == "160x120") ? 7 : 8;
   localparam int SH_B = (RESOLUTION == "160x120") ? 5 : 6;

   assign mem_address = (AW'(y) << SH_A) + (AW'(y) << SH_B) + AW'(x);
endmodule

// File: rtl/vga_rect_fill.sv
// vga_rect_fill: rectangle fill engine feeding video memory.
// Accepts one rectangle at a time, clips it to the screen and emits one
// registered write per cycle in raster order, then pulses done.
//   vga_clock in  clock
//   resetn    in  asynchronous active-low reset
//   bus       slave modport of vga_rect_fill_if (command + write port)
module vga_rect_fill
   import vga_rect_fill_pkg::*;
#(
   parameter string RESOLUTION              = "320x240",
   parameter int    BITS_PER_COLOUR_CHANNEL = 4,
   parameter string MONOCHROME              = "FALSE"
) (
   input logic            vga_clock,
   input logic            resetn,
   vga_rect_fill_if.slave bus
);
   localparam bit LO   = (RESOLUTION == "160x120");
   localparam int XRES = LO ? XRES_LO : XRES_HI;
   localparam int YRES = LO ? YRES_LO : YRES_HI;
   localparam int XW   = LO ? XW_LO : XW_HI;
   localparam int YW   = LO ? YW_LO : YW_HI;
   localparam int AW   = LO ? AW_LO : AW_HI;
   localparam int CW   = colour_width(MONOCHROME == "TRUE", BITS_PER_COLOUR_CHANNEL);

   localparam logic [XW:0] XRES_E = (XW+1)'(XRES);
   localparam logic [YW:0] YRES_E = (YW+1)'(YRES);
   localparam logic [XW:0] ONE_XE = (XW+1)'(1);
   localparam logic [YW:0] ONE_YE = (YW+1)'(1);

   state_t        state, state_next;
   logic          settle;
   logic [XW-1:0] cx, x0;
   logic [YW-1:0] cy;
   logic [XW:0]   x_last, x_end, x_stop;
   logic [YW:0]   y_last, y_end, y_stop;
   logic [CW-1:0] colour;
   logic          empty, accept, last_x, last_dot;
   logic [AW-1:0] addr;
   logic          wr_en_r;
   logic [AW-1:0] wr_address_r;
   logic [CW-1:0] wr_colour_r;

   vga_address_translator #(
      .RESOLUTION (RESOLUTION),
      .XW         (XW),
      .YW         (YW),
      .AW         (AW)
   ) u_translator (
      .x           (cx),
      .y           (cy),
      .mem_address (addr)
   );

   // Clipping: ends are computed one bit wider so x+w / y+h never wrap.
   always_comb begin
      x_end    = {1'b0, bus.cmd_x} + {1'b0, bus.cmd_w};
      y_end    = {1'b0, bus.cmd_y} + {1'b0, bus.cmd_h};
      x_stop   = (x_end > XRES_E) ? XRES_E : x_end;
      y_stop   = (y_end > YRES_E) ? YRES_E : y_end;
      empty    = ({1'b0, bus.cmd_x} >= XRES_E) || ({1'b0, bus.cmd_y} >= YRES_E) ||
                 (bus.cmd_w == '0) || (bus.cmd_h == '0);
      accept   = (state == IDLE) && bus.cmd_valid;
      last_x   = ({1'b0, cx} == x_last);
      last_dot = last_x && ({1'b0, cy} == y_last);
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = empty ? DONE : FILL;
         FILL:    if (last_dot) state_next = DONE;
         DONE:    if (!settle) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge vga_clock or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_next;
   end

   // An empty command lingers one extra cycle in DONE so its done pulse
   // lands at the same latency a first write would have.
   always_ff @(posedge vga_clock or negedge resetn) begin
      if (!resetn) begin
         settle <= 1'b0;
         cx     <= '0;
         cy     <= '0;
         x0     <= '0;
         x_last <= '0;
         y_last <= '0;
         colour <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               settle <= empty;
               cx     <= bus.cmd_x;
               cy     <= bus.cmd_y;
               x0     <= bus.cmd_x;
               x_last <= x_stop - ONE_XE;
               y_last <= y_stop - ONE_YE;
               colour <= bus.cmd_colour;
            end
            FILL: begin
               if (last_x) begin
                  cx <= x0;
                  cy <= cy + YW'(1);
               end else begin
                  cx <= cx + XW'(1);
               end
            end
            DONE:    settle <= 1'b0;
            default: settle <= 1'b0;
         endcase
      end
   end

   // Write port registers; address and colour only change on a write.
   always_ff @(posedge vga_clock or negedge resetn) begin
      if (!resetn) begin
         wr_en_r      <= 1'b0;
         wr_address_r <= '0;
         wr_colour_r  <= '0;
      end else begin
         wr_en_r <= (state == FILL);
         if (state == FILL) begin
            wr_address_r <= addr;
            wr_colour_r  <= colour;
         end
      end
   end

   assign bus.cmd_ready  = (state == IDLE);
   assign bus.busy       = (state != IDLE);
   assign bus.done       = (state == DONE) && !settle;
   assign bus.wr_en      = wr_en_r;
   assign bus.wr_address = wr_address_r;
   assign bus.wr_colour  = wr_colour_r;
endmodule

// File: tb/tb_vga_rect_fill.sv
// Self-checking bench for vga_rect_fill (320x240, 12-bit colour).
module tb_vga_rect_fill;
   logic vga_clock = 1'b0;
   logic resetn    = 1'b0;
   int   checks    = 0;
   int   failures  = 0;
   int   oob       = 0;
   int   exp_q[$];

   vga_rect_fill_if #(.XW(9), .YW(8), .AW(17), .CW(12)) bus ();

   vga_rect_fill #(
      .RESOLUTION              ("320x240"),
      .BITS_PER_COLOUR_CHANNEL (4),
      .MONOCHROME              ("FALSE")
   ) dut (
      .vga_clock (vga_clock),
      .resetn    (resetn),
      .bus       (bus)
   );

   initial forever #5 vga_clock = ~vga_clock;

   always @(negedge vga_clock)
      if (bus.wr_en === 1'b1 && bus.wr_address >= 17'd76800) oob++;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: every on-screen dot of the rectangle in raster order.
   task automatic build_exp(input int x, input int y, input int w, input int h);
      exp_q.delete();
      for (int yy = y; yy < y + h; yy++)
         for (int xx = x; xx < x + w; xx++)
            if (xx < 320 && yy < 240) exp_q.push_back(yy * 320 + xx);
   endtask

   task automatic wait_ready();
      @(negedge vga_clock);
      for (int i = 0; i < 3000 && bus.cmd_ready !== 1'b1; i++) @(negedge vga_clock);
      if (bus.cmd_ready !== 1'b1) check_eq("ready_timeout", 32'(bus.cmd_ready), 1);
   endtask

   task automatic drive_cmd(input int x, input int y, input int w, input int h, input int col);
      bus.cmd_x      = 9'(x);
      bus.cmd_y      = 8'(y);
      bus.cmd_w      = 9'(w);
      bus.cmd_h      = 8'(h);
      bus.cmd_colour = 12'(col);
   endtask

   task automatic run_cmd(input int x, input int y, input int w, input int h, input int col);
      int n;
      build_exp(x, y, w, h);
      n = exp_q.size();
      wait_ready();
      drive_cmd(x, y, w, h, col);
      bus.cmd_valid = 1'b1;
      @(posedge vga_clock);
      #1 bus.cmd_valid = 1'b0;
      @(negedge vga_clock);
      check_eq("ready_after_accept", 32'(bus.cmd_ready), 0);
      check_eq("busy_after_accept", 32'(bus.busy), 1);
      if (n == 0) begin
         @(negedge vga_clock);
         check_eq("empty_no_write", 32'(bus.wr_en), 0);
         check_eq("empty_done", 32'(bus.done), 1);
         @(negedge vga_clock);
         check_eq("empty_ready_back", 32'(bus.cmd_ready), 1);
         check_eq("empty_done_low", 32'(bus.done), 0);
         check_eq("empty_still_no_write", 32'(bus.wr_en), 0);
      end else begin
         for (int k = 0; k < n; k++) begin
            @(negedge vga_clock);
            check_eq("wr_en", 32'(bus.wr_en), 1);
            check_eq("wr_address", 32'(bus.wr_address), 32'(exp_q[k]));
            check_eq("wr_colour", 32'(bus.wr_colour), 32'(col));
            check_eq("done_timing", 32'(bus.done), (k == n - 1) ? 1 : 0);
         end
         @(negedge vga_clock);
         check_eq("wr_en_after_fill", 32'(bus.wr_en), 0);
         check_eq("ready_after_fill", 32'(bus.cmd_ready), 1);
         check_eq("done_after_fill", 32'(bus.done), 0);
      end
   endtask

   initial begin
      int first1, first2, cnt1;
      bus.cmd_valid = 1'b1;
      drive_cmd(10, 5, 2, 2, 12'hF00);

      // reset held with a pending command
      for (int i = 0; i < 3; i++) begin
         @(negedge vga_clock);
         check_eq("rst_ready", 32'(bus.cmd_ready), 1);
         check_eq("rst_wr_en", 32'(bus.wr_en), 0);
         check_eq("rst_done", 32'(bus.done), 0);
         check_eq("rst_busy", 32'(bus.busy), 0);
         check_eq("rst_wr_address", 32'(bus.wr_address), 0);
      end
      bus.cmd_valid = 1'b0;
      resetn = 1'b1;

      // directed: basic, empty, clipped
      run_cmd(10, 5, 2, 2, 12'hF00);
      run_cmd(10, 5, 0, 2, 12'h0F0);
      run_cmd(320, 5, 4, 2, 12'h00F);
      run_cmd(318, 239, 5, 3, 12'hABC);
      run_cmd(0, 0, 1, 1, 12'h123);

      // back-to-back with command held high through the fill
      build_exp(20, 30, 3, 2);
      wait_ready();
      drive_cmd(20, 30, 3, 2, 12'h111);
      bus.cmd_valid = 1'b1;
      @(posedge vga_clock);
      #1 drive_cmd(50, 60, 2, 2, 12'h222);
      first1 = -1;
      first2 = -1;
      cnt1   = 0;
      for (int c = 1; c <= 40 && first2 < 0; c++) begin
         @(negedge vga_clock);
         if (bus.wr_en === 1'b1) begin
            if (bus.wr_address == 17'd19250) first2 = c;
            else begin
               cnt1++;
               if (first1 < 0 && bus.wr_address == 17'(exp_q[0])) first1 = c;
            end
         end
      end
      bus.cmd_valid = 1'b0;
      check_eq("b2b_first_cmd_writes", 32'(cnt1), 32'(exp_q.size()));
      check_eq("b2b_first_write_gap", 32'(first2 - first1), 32'(exp_q.size() + 2));
      wait_ready();

      // asynchronous abort mid-fill
      wait_ready();
      drive_cmd(100, 50, 4, 4, 12'h555);
      bus.cmd_valid = 1'b1;
      @(posedge vga_clock);
      #1 bus.cmd_valid = 1'b0;
      @(negedge vga_clock);
      for (int i = 0; i < 3; i++) @(negedge vga_clock);
      check_eq("abort_third_write", 32'(bus.wr_address), 50 * 320 + 102);
      #2 resetn = 1'b0;
      #1;
      check_eq("abort_wr_en", 32'(bus.wr_en), 0);
      check_eq("abort_ready", 32'(bus.cmd_ready), 1);
      check_eq("abort_busy", 32'(bus.busy), 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge vga_clock);
         check_eq("abort_hold_no_write", 32'(bus.wr_en), 0);
      end
      resetn = 1'b1;
      @(negedge vga_clock);
      check_eq("abort_release_ready", 32'(bus.cmd_ready), 1);
      check_eq("abort_release_no_write", 32'(bus.wr_en), 0);
      run_cmd(7, 9, 3, 3, 12'h777);

      // randomized commands, some crossing the right/bottom edges
      for (int t = 0; t < 25; t++) begin
         int x, y, w, h, col;
         x   = $urandom_range(0, 330);
         y   = $urandom_range(0, 245);
         w   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 511) : $urandom_range(0, 12);
         h   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 5);
         if (w > 40 && h > 5) h = 5;
         col = $urandom_range(0, 4095);
         run_cmd(x, y, w, h, col);
      end

      check_eq("offscreen_writes", 32'(oob), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
